// File: rtl/lsu.sv
// Load/store stage: aligns and issues one memory request per load/store,
// extends load data, and forwards non-memory results to writeback.
module lsu #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_load,
  input  logic              in_store,
  input  logic [2:0]        in_funct3,
  input  logic [XLEN-1:0]   in_res,
  input  logic [XLEN-1:0]   in_sdata,
  input  logic [4:0]        in_rd,
  input  logic              in_wen,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wmask,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_data,
  output logic [4:0]        out_rd,
  output logic              out_wen,
  output logic              out_fault
);

  localparam int NB = XLEN / 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        r_state;
  logic              r_is_load;
  logic              r_is_store;
  logic [2:0]        r_funct3;
  logic [2:0]        r_off;
  logic [ADDR_W-1:0] r_addr;
  logic [XLEN-1:0]   r_wdata;
  logic [NB-1:0]     r_wmask;
  logic [XLEN-1:0]   r_data;
  logic [4:0]        r_rd;
  logic              r_wen;
  logic              r_fault;

  logic              w_accept;
  logic              w_load;
  logic              w_store;
  logic [2:0]        w_off;
  logic              w_misalign;
  logic              w_illegal;
  logic              w_fault;
  logic              w_mem;
  logic [NB-1:0]     w_size_mask;
  logic [NB-1:0]     w_wmask;
  logic [XLEN-1:0]   w_wdata;
  logic [XLEN-1:0]   w_rshift;
  logic [XLEN-1:0]   w_ext;
  logic              w_unused_hi;

  assign w_unused_hi = &{1'b0, in_res[XLEN-1:ADDR_W]};

  assign w_accept = in_valid & (r_state == S_IDLE);
  // A record flagged as both load and store is treated as a load.
  assign w_load   = in_load;
  assign w_store  = in_store & ~in_load;
  assign w_off    = in_res[2:0];

  always_comb begin
    w_misalign = 1'b0;
    case (in_funct3[1:0])
      2'b01:   w_misalign = w_off[0];
      2'b10:   w_misalign = (w_off[1:0] != 2'b00);
      2'b11:   w_misalign = (w_off != 3'b000);
      default: w_misalign = 1'b0;
    endcase
  end

  assign w_illegal = (w_load & (in_funct3 == 3'b111)) | (w_store & in_funct3[2]);
  assign w_fault   = (w_load | w_store) & (w_misalign | w_illegal);
  assign w_mem     = (w_load | w_store) & ~w_fault;

  always_comb begin
    w_size_mask = '0;
    case (in_funct3[1:0])
      2'b00:   w_size_mask = NB'(8'h01);
      2'b01:   w_size_mask = NB'(8'h03);
      2'b10:   w_size_mask = NB'(8'h0F);
      default: w_size_mask = NB'(8'hFF);
    endcase
  end

  assign w_wmask = w_size_mask << w_off;
  assign w_wdata = in_sdata << {w_off, 3'b000};

  assign w_rshift = mem_rdata >> {r_off, 3'b000};

  always_comb begin
    w_ext = w_rshift;
    case (r_funct3)
      3'b000:  w_ext = {{(XLEN-8){w_rshift[7]}},   w_rshift[7:0]};
      3'b001:  w_ext = {{(XLEN-16){w_rshift[15]}}, w_rshift[15:0]};
      3'b010:  w_ext = {{(XLEN-32){w_rshift[31]}}, w_rshift[31:0]};
      3'b100:  w_ext = {{(XLEN-8){1'b0}},  w_rshift[7:0]};
      3'b101:  w_ext = {{(XLEN-16){1'b0}}, w_rshift[15:0]};
      3'b110:  w_ext = {{(XLEN-32){1'b0}}, w_rshift[31:0]};
      default: w_ext = w_rshift;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_is_load  <= 1'b0;
      r_is_store <= 1'b0;
      r_funct3   <= '0;
      r_off      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wmask    <= '0;
      r_data     <= '0;
      r_rd       <= '0;
      r_wen      <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_is_load  <= w_load;
            r_is_store <= w_store;
            r_funct3   <= in_funct3;
            r_off      <= w_off;
            r_addr     <= {in_res[ADDR_W-1:3], 3'b000};
            r_wdata    <= w_store ? w_wdata : '0;
            r_wmask    <= (w_store & ~w_fault) ? w_wmask : '0;
            r_data     <= w_fault ? '0 : in_res;
            r_rd       <= in_rd;
            r_wen      <= in_wen & ~w_store & ~w_fault;
            r_fault    <= w_fault;
            r_state    <= w_mem ? S_REQ : S_DONE;
          end
        end
        S_REQ: begin
          if (mem_req_ready) r_state <= r_is_load ? S_WAIT : S_DONE;
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            r_data  <= w_ext;
            r_state <= S_DONE;
          end
        end
        default: begin
          if (out_ready) r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready      = (r_state == S_IDLE);
  assign mem_req_valid = (r_state == S_REQ);
  assign mem_addr      = r_addr;
  assign mem_wen       = r_is_store;
  assign mem_wdata     = r_wdata;
  assign mem_wmask     = r_wmask;
  assign out_valid     = (r_state == S_DONE);
  assign out_data      = r_data;
  assign out_rd        = r_rd;
  assign out_wen       = r_wen;
  assign out_fault     = r_fault;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: expected writeback records are queued at issue
// and compared when the stage hands them off.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_load, in_store, in_wen;
  logic [2:0]  in_funct3;
  logic [63:0] in_res, in_sdata;
  logic [4:0]  in_rd;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_rvalid;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;
  logic        out_valid, out_ready, out_wen, out_fault;
  logic [63:0] out_data;
  logic [4:0]  out_rd;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  rd;
    logic        wen;
    logic        fault;
    bit          cmp_data;
  } rec_t;

  rec_t sb[$];
  rec_t mon_e;
  int   n_chk  = 0;
  int   n_pass = 0;

  lsu #(.XLEN(64), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_load(in_load), .in_store(in_store),
    .in_funct3(in_funct3), .in_res(in_res), .in_sdata(in_sdata), .in_rd(in_rd), .in_wen(in_wen),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_rd(out_rd), .out_wen(out_wen), .out_fault(out_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexpected_wb", 64'd1, 64'd0);
      else begin
        mon_e = sb.pop_front();
        if (mon_e.cmp_data) chk("wb_data", out_data, mon_e.data);
        chk("wb_rd", 64'(out_rd), 64'(mon_e.rd));
        chk("wb_wen", 64'(out_wen), 64'(mon_e.wen));
        chk("wb_fault", 64'(out_fault), 64'(mon_e.fault));
      end
    end
  end

  task automatic push(input logic [63:0] d, input logic [4:0] rd, input logic wen,
                      input logic flt, input bit cmpd);
    rec_t e;
    e.data = d; e.rd = rd; e.wen = wen; e.fault = flt; e.cmp_data = cmpd;
    sb.push_back(e);
  endtask

  // Returns #1 after the accepting edge.
  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [63:0] res, input logic [63:0] sd,
                       input logic [4:0] rd, input logic wen);
    @(posedge clk); #1;
    chk("issue_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_load = ld; in_store = st; in_funct3 = f3;
    in_res = res; in_sdata = sd; in_rd = rd; in_wen = wen;
    @(posedge clk); #1;
    in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0;
    in_res = 64'hDEAD_DEAD_DEAD_DEAD; in_sdata = '0; in_rd = 5'd31;
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #2;
      if (sb.size() == 0) break;
    end
    if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] rdata, input logic [63:0] exp,
                         input logic [4:0] rd, input int lat);
    logic [31:0] ea;
    ea = addr[31:0] & 32'hFFFF_FFF8;
    mem_req_ready = 1'b1;
    push(exp, rd, 1'b1, 1'b0, 1'b1);
    issue(1'b1, 1'b0, f3, addr, 64'd0, rd, 1'b1);
    @(negedge clk);
    chk("ld_req_valid", 64'(mem_req_valid), 64'd1);
    chk("ld_addr", 64'(mem_addr), 64'(ea));
    chk("ld_wen", 64'(mem_wen), 64'd0);
    chk("ld_wmask", 64'(mem_wmask), 64'd0);
    @(posedge clk); #1;
    repeat (lat) begin
      @(negedge clk);
      chk("ld_wait_novalid", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
    end
    mem_rvalid = 1'b1; mem_rdata = rdata;
    @(posedge clk); #1;
    mem_rvalid = 1'b0; mem_rdata = {$urandom, $urandom};
    drain();
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [63:0] addr,
                          input logic [63:0] sd, input logic [7:0] exp_mask,
                          input logic [63:0] exp_wdata, input logic [4:0] rd, input int hold);
    logic [31:0] ea;
    ea = addr[31:0] & 32'hFFFF_FFF8;
    mem_req_ready = 1'b0;
    push(64'd0, rd, 1'b0, 1'b0, 1'b0);
    issue(1'b0, 1'b1, f3, addr, sd, rd, 1'b1);
    repeat (hold) begin
      @(negedge clk);
      chk("st_req_valid", 64'(mem_req_valid), 64'd1);
      chk("st_addr", 64'(mem_addr), 64'(ea));
      chk("st_wen", 64'(mem_wen), 64'd1);
      chk("st_wmask", 64'(mem_wmask), 64'(exp_mask));
      chk("st_wdata", mem_wdata, exp_wdata);
    end
    @(posedge clk); #1 mem_req_ready = 1'b1;
    @(posedge clk); #1 mem_req_ready = 1'b0;
    drain();
  endtask

  task automatic do_fault(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [63:0] addr, input logic [4:0] rd);
    mem_req_ready = 1'b1;
    push(64'd0, rd, 1'b0, 1'b1, 1'b1);
    issue(ld, st, f3, addr, 64'hFFFF_FFFF_FFFF_FFFF, rd, 1'b1);
    @(negedge clk);
    chk("flt_noreq", 64'(mem_req_valid), 64'd0);
    chk("flt_valid", 64'(out_valid), 64'd1);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 0; in_load = 0; in_store = 0; in_funct3 = 0;
    in_res = 0; in_sdata = 0; in_rd = 0; in_wen = 0;
    mem_req_ready = 0; mem_rvalid = 0; mem_rdata = 0; out_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_wmask", 64'(mem_wmask), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // ALU pass-through
    out_ready = 1'b1;
    push(64'h1234, 5'd5, 1'b1, 1'b0, 1'b1);
    issue(1'b0, 1'b0, 3'b011, 64'h1234, 64'd0, 5'd5, 1'b1);
    @(negedge clk);
    chk("pt_valid", 64'(out_valid), 64'd1);
    chk("pt_busy", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("pt_ready_back", 64'(in_ready), 64'd1);
    chk("pt_valid_drop", 64'(out_valid), 64'd0);
    drain();

    // Loads
    do_load(3'b000, 64'h8000_0003, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80, 5'd1, 0);
    do_load(3'b101, 64'h8000_0006, 64'hBEEF_0000_0000_0000, 64'h0000_0000_0000_BEEF, 5'd2, 2);
    do_load(3'b010, 64'h8000_0004, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321, 5'd3, 0);
    do_load(3'b110, 64'h8000_0004, 64'h8765_4321_0000_0000, 64'h0000_0000_8765_4321, 5'd4, 1);
    do_load(3'b011, 64'h8000_0008, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 5'd6, 0);
    do_load(3'b001, 64'h8000_0002, 64'h0000_0000_8001_0000, 64'hFFFF_FFFF_FFFF_8001, 5'd7, 0);
    do_load(3'b100, 64'h8000_0007, 64'hF000_0000_0000_0000, 64'h0000_0000_0000_00F0, 5'd8, 0);

    // Stores
    do_store(3'b010, 64'h8000_0004, 64'h1122_3344, 8'hF0, 64'h1122_3344_0000_0000, 5'd10, 3);
    do_store(3'b000, 64'h8000_0003, 64'hAB, 8'h08, 64'h0000_0000_AB00_0000, 5'd11, 1);
    do_store(3'b001, 64'h8000_0006, 64'hBEEF, 8'hC0, 64'hBEEF_0000_0000_0000, 5'd12, 2);
    do_store(3'b011, 64'h8000_0010, 64'hDEAD_BEEF_0000_0001, 8'hFF, 64'hDEAD_BEEF_0000_0001, 5'd13, 1);

    // Faults
    do_fault(1'b1, 1'b0, 3'b011, 64'h8000_0004, 5'd14);
    do_fault(1'b1, 1'b0, 3'b111, 64'h8000_0000, 5'd15);
    do_fault(1'b0, 1'b1, 3'b100, 64'h8000_0000, 5'd16);
    do_fault(1'b0, 1'b1, 3'b001, 64'h8000_0001, 5'd17);
    do_fault(1'b1, 1'b0, 3'b010, 64'h8000_0002, 5'd18);

    // Writeback backpressure
    out_ready = 1'b0;
    push(64'hCAFE, 5'd7, 1'b1, 1'b0, 1'b1);
    issue(1'b0, 1'b0, 3'b000, 64'hCAFE, 64'd0, 5'd7, 1'b1);
    repeat (4) begin
      @(negedge clk);
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_data", out_data, 64'hCAFE);
      chk("bp_rd", 64'(out_rd), 64'd7);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    drain();

    // Reset while waiting for read data; late rvalid must be ignored
    mem_req_ready = 1'b1;
    issue(1'b1, 1'b0, 3'b010, 64'h8000_0000, 64'd0, 5'd9, 1'b1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; mem_req_ready = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 64'h5555_5555_5555_5555;
    @(posedge clk); #1 mem_rvalid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rstw_out_valid", 64'(out_valid), 64'd0);
      chk("rstw_in_ready", 64'(in_ready), 64'd1);
      chk("rstw_req_valid", 64'(mem_req_valid), 64'd0);
    end

    push(64'h77, 5'd20, 1'b0, 1'b0, 1'b1);
    issue(1'b0, 1'b0, 3'b000, 64'h77, 64'd0, 5'd20, 1'b0);
    drain();

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
